// File: rtl/fifo_serializer.sv
// Pops words from the TX async-FIFO read port and shifts each one onto the line as a
// framed serial stream: start bit, data LSB first, optional parity, stop bit(s); idle high.
module fifo_serializer #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             empty_i,
    input  logic [WIDTH-1:0] r_data_i,
    input  logic             rd_error_i,
    output logic             rd_en_o,
    output logic             serial_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             underrun_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]     STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t             state_q, state_next;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_next;
    logic [IDX_W-1:0]   idx_q, idx_next;
    logic [WIDTH-1:0]   shift_q, shift_next;
    logic               parity_q, parity_next;
    logic               serial_q, serial_next;
    logic               done_q, done_next;
    logic               underrun_q;
    logic               bit_end;
    logic               start_ok;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign start_ok = enable_i && !empty_i;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next  = state_q;
        cnt_next    = '0;
        idx_next    = '0;
        shift_next  = shift_q;
        parity_next = parity_q;
        done_next   = 1'b0;

        if (state_q inside {START, DATA, PARITY, STOP})
            cnt_next = bit_end ? '0 : cnt_q + CNT_WIDTH'(1);

        // One index serves both the data bits and the stop bits.
        if (state_q inside {DATA, STOP}) begin
            idx_next = idx_q;
            if (bit_end)
                idx_next = (idx_q == ((state_q == DATA) ? IDX_LAST : STOP_LAST))
                           ? '0 : idx_q + IDX_W'(1);
        end

        case (state_q)
            IDLE:   if (start_ok) state_next = FETCH;
            FETCH:  state_next = LOAD;
            LOAD: begin
                shift_next  = r_data_i;
                parity_next = (^r_data_i) ^ 1'(PARITY_ODD);
                state_next  = START;
            end
            START:  if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_q >> 1;
                    if (idx_q == IDX_LAST)
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_next = STOP;
            STOP: begin
                if (bit_end && idx_q == STOP_LAST) begin
                    done_next  = 1'b1;
                    state_next = start_ok ? FETCH : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The line is registered, so it is driven from the state being entered.
        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
            PARITY:  serial_next = parity_next;
            default: serial_next = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            serial_q   <= 1'b1;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_next;
            cnt_q      <= cnt_next;
            idx_q      <= idx_next;
            shift_q    <= shift_next;
            parity_q   <= parity_next;
            serial_q   <= serial_next;
            done_q     <= done_next;
            if (rd_error_i) underrun_q <= 1'b1;
        end
    end

    assign rd_en_o      = (state_q == FETCH);
    assign busy_o       = (state_q != IDLE);
    assign serial_o     = serial_q;
    assign frame_done_o = done_q;
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer: three instances (even parity, odd parity, no parity)
// share a small FIFO model; each scenario task checks the serial stream cycle by cycle.
module tb_fifo_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] en = '0;
    logic       empty;
    logic [7:0] r_data = '0;
    logic       rd_error = 1'b0;
    logic [2:0] rd, ser, busy, done, und;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // FIFO model: pops on the rd_en of the selected instance, data valid the next cycle.
    logic [7:0] mem [16];
    logic [3:0] wr_ptr = '0;
    logic [3:0] rd_ptr = '0;
    int         sel = 0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd[sel] && !empty) begin
            r_data <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 4'd1;
        end
    end

    int rd_cnt [3] = '{0, 0, 0};
    int done_cnt [3] = '{0, 0, 0};
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd[k]) rd_cnt[k] <= rd_cnt[k] + 1;
            if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    fifo_serializer #(.PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en[0]), .empty_i(empty),
        .r_data_i(r_data), .rd_error_i(rd_error), .rd_en_o(rd[0]), .serial_o(ser[0]),
        .busy_o(busy[0]), .frame_done_o(done[0]), .underrun_o(und[0])
    );
    fifo_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en[1]), .empty_i(empty),
        .r_data_i(r_data), .rd_error_i(rd_error), .rd_en_o(rd[1]), .serial_o(ser[1]),
        .busy_o(busy[1]), .frame_done_o(done[1]), .underrun_o(und[1])
    );
    fifo_serializer #(.PARITY_EN(0), .PARITY_ODD(0)) dut_nopar (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en[2]), .empty_i(empty),
        .r_data_i(r_data), .rd_error_i(rd_error), .rd_en_o(rd[2]), .serial_o(ser[2]),
        .busy_o(busy[2]), .frame_done_o(done[2]), .underrun_o(und[2])
    );

    logic cap      [200];
    logic cap_busy [200];
    logic cap_done [200];

    task automatic push(input logic [7:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic wait_start(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ser[d] === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic capture(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            cap[i]      = ser[d];
            cap_busy[i] = busy[d];
            cap_done[i] = done[d];
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({ser[k], busy[k], rd[k], done[k], und[k]} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: ser/busy/rd/done/und=%b expected 10000", k,
                         {ser[k], busy[k], rd[k], done[k], und[k]});
            end
        end
        rst_n = 1'b1;
        sel = 0;
        push(8'hA5);
        @(negedge clk);
        en[0] = 1'b1;
        wait_start(0, ok);
        en[0] = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_start_timeout: no start bit seen, expected one");
            return;
        end
        repeat (9) @(negedge clk);
        n_checks++;
        if ({ser[0], busy[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_pre_data: ser/busy=%b expected 01", {ser[0], busy[0]});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ser[0], busy[0], rd[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_async: ser/busy/rd=%b expected 100", {ser[0], busy[0], rd[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_even();
        bit ok;
        logic [10:0] seq = 11'b1_0_10100101_0;
        int rd0 = rd_cnt[0];
        int dn0 = done_cnt[0];
        sel = 0;
        push(8'hA5);
        en[0] = 1'b1;
        wait_start(0, ok);
        en[0] = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_start_timeout: no start bit seen, expected one");
            return;
        end
        capture(0, 46);
        for (int i = 0; i < 44; i++) begin
            n_checks++;
            if (cap[i] !== seq[i / 4]) begin
                n_fail++;
                $display("FAIL single_bit cycle %0d: got %b expected %b", i, cap[i], seq[i / 4]);
            end
        end
        n_checks++;
        if ({cap_busy[43], cap_busy[44], cap[44], cap_done[43], cap_done[44], cap_done[45]} !== 6'b101010) begin
            n_fail++;
            $display("FAIL single_end: busy43/busy44/ser44/done43/done44/done45=%b expected 101010",
                     {cap_busy[43], cap_busy[44], cap[44], cap_done[43], cap_done[44], cap_done[45]});
        end
        n_checks++;
        if (rd_cnt[0] - rd0 !== 1 || done_cnt[0] - dn0 !== 1) begin
            n_fail++;
            $display("FAIL single_pulses: rd_en=%0d frame_done=%0d expected 1 and 1",
                     rd_cnt[0] - rd0, done_cnt[0] - dn0);
        end
    endtask

    task automatic test_odd_parity();
        bit ok;
        logic [10:0] seq = 11'b1_1_11111111_0;
        int rd0 = rd_cnt[1];
        sel = 1;
        push(8'hFF);
        en[1] = 1'b1;
        wait_start(1, ok);
        en[1] = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL odd_start_timeout: no start bit seen, expected one");
            return;
        end
        capture(1, 45);
        for (int i = 0; i < 44; i++) begin
            n_checks++;
            if (cap[i] !== seq[i / 4]) begin
                n_fail++;
                $display("FAIL odd_bit cycle %0d: got %b expected %b", i, cap[i], seq[i / 4]);
            end
        end
        n_checks++;
        if (rd_cnt[1] - rd0 !== 1 || cap_busy[44] !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_end: rd_en=%0d busy=%b expected 1 and 0", rd_cnt[1] - rd0, cap_busy[44]);
        end
    endtask

    task automatic test_no_parity();
        bit ok;
        logic [9:0] seq = 10'b1_01011010_0;
        sel = 2;
        push(8'h5A);
        en[2] = 1'b1;
        wait_start(2, ok);
        en[2] = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL nopar_start_timeout: no start bit seen, expected one");
            return;
        end
        capture(2, 42);
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (cap[i] !== seq[i / 4]) begin
                n_fail++;
                $display("FAIL nopar_bit cycle %0d: got %b expected %b", i, cap[i], seq[i / 4]);
            end
        end
        n_checks++;
        if ({cap_busy[39], cap_busy[40], cap[40], cap_done[40]} !== 4'b1011) begin
            n_fail++;
            $display("FAIL nopar_length: busy39/busy40/ser40/done40=%b expected 1011",
                     {cap_busy[39], cap_busy[40], cap[40], cap_done[40]});
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [10:0] seqs [3];
        int rd0 = rd_cnt[0];
        int dn0 = done_cnt[0];
        seqs[0] = 11'b1_1_00000001_0;
        seqs[1] = 11'b1_1_10000000_0;
        seqs[2] = 11'b1_0_00111100_0;
        sel = 0;
        push(8'h01);
        push(8'h80);
        push(8'h3C);
        en[0] = 1'b1;
        wait_start(0, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            en[0] = 1'b0;
            $display("FAIL b2b_start_timeout: no start bit seen, expected one");
            return;
        end
        capture(0, 136);
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 46; j++) begin
                logic e;
                if (f == 2 && j >= 44) break;
                e = (j < 44) ? seqs[f][j / 4] : 1'b1;
                n_checks++;
                if (cap[f * 46 + j] !== e) begin
                    n_fail++;
                    $display("FAIL b2b_bit frame %0d cycle %0d: got %b expected %b", f, j, cap[f * 46 + j], e);
                end
            end
        end
        repeat (3) @(negedge clk);
        en[0] = 1'b0;
        n_checks++;
        if (rd_cnt[0] - rd0 !== 3 || done_cnt[0] - dn0 !== 3 || busy[0] !== 1'b0 || ser[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: rd_en=%0d frame_done=%0d busy=%b ser=%b expected 3 3 0 1",
                     rd_cnt[0] - rd0, done_cnt[0] - dn0, busy[0], ser[0]);
        end
    endtask

    task automatic test_empty_underrun();
        int rd0 = rd_cnt[0];
        sel = 0;
        en[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (rd[0] !== 1'b0 || busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_no_read cycle %0d: rd_en=%b busy=%b expected 0 0", i, rd[0], busy[0]);
            end
        end
        en[0] = 1'b0;
        n_checks++;
        if (rd_cnt[0] !== rd0 || und[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_pre_err: rd_en=%0d underrun=%b expected 0 0", rd_cnt[0] - rd0, und[0]);
        end
        rd_error = 1'b1;
        @(negedge clk);
        rd_error = 1'b0;
        n_checks++;
        if (und[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_set: got %b expected 1", und[0]);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (und[0] !== 1'b1 || und[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_sticky: dut0=%b dut2=%b expected 1 1", und[0], und[2]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (und[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_reset: got %b expected 0", und[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        bit ok;
        logic [10:0] seq = 11'b1_0_00111100_0;
        int rd0 = rd_cnt[0];
        sel = 0;
        push(8'h3C);
        push(8'h5A);
        en[0] = 1'b1;
        wait_start(0, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            en[0] = 1'b0;
            $display("FAIL drop_start_timeout: no start bit seen, expected one");
            return;
        end
        capture(0, 10);
        en[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (cap[i] !== seq[i / 4]) begin
                n_fail++;
                $display("FAIL drop_head cycle %0d: got %b expected %b", i, cap[i], seq[i / 4]);
            end
        end
        capture(0, 34);
        for (int i = 0; i < 34; i++) begin
            n_checks++;
            if (cap[i] !== seq[(i + 10) / 4]) begin
                n_fail++;
                $display("FAIL drop_tail cycle %0d: got %b expected %b", i + 10, cap[i], seq[(i + 10) / 4]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (ser[0] !== 1'b1 || rd[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_idle cycle %0d: ser=%b rd_en=%b expected 1 0", i, ser[0], rd[0]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (rd_cnt[0] - rd0 !== 1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_end: rd_en=%0d busy=%b expected 1 0", rd_cnt[0] - rd0, busy[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_even();
        test_odd_parity();
        test_no_parity();
        test_back_to_back();
        test_empty_underrun();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
